// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the data memory arbiter and data_mem.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares single-port data_mem between the CPU and a DMA/loader: CPU priority with a burst limit.
// Define DMEM_ARB_STATS_EN to add saturating grant/stall statistics counters.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic         CLK,
    input  logic         reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]  cpu_grant_ct,
    output logic [15:0]  dma_grant_ct,
    output logic [15:0]  stall_ct
`endif
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    localparam logic [1:0] LAT_INIT  = 2'(RD_LAT);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [1:0] lat_ct, lat_ct_nxt;
    logic [3:0] burst_ct, burst_ct_nxt;
    logic       owner_dma, owner_dma_nxt;
    logic       cpu_win, dma_win;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_ct    <= 2'd0;
            burst_ct  <= 4'd0;
            owner_dma <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_ct    <= lat_ct_nxt;
            burst_ct  <= burst_ct_nxt;
            owner_dma <= owner_dma_nxt;
        end
    end

    // Outputs are gated by reset so they read 0 the instant reset rises.
    always_comb begin
        state_nxt      = state;
        lat_ct_nxt     = lat_ct;
        burst_ct_nxt   = burst_ct;
        owner_dma_nxt  = owner_dma;
        cpu_win        = 1'b0;
        dma_win        = 1'b0;
        bus.cpu_stall    = 1'b0;
        bus.cpu_gnt      = 1'b0;
        bus.cpu_rvalid   = 1'b0;
        bus.cpu_rdata    = '0;
        bus.dma_gnt      = 1'b0;
        bus.dma_rvalid   = 1'b0;
        bus.dma_rdata    = '0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    cpu_win = bus.cpu_req && (!bus.dma_req || burst_ct != BURST_LIM);
                    dma_win = bus.dma_req && !cpu_win;
                    if (cpu_win) begin
                        bus.cpu_gnt      = 1'b1;
                        bus.mem_addr     = bus.cpu_addr;
                        bus.mem_wdata    = bus.cpu_wdata;
                        bus.mem_write_en = bus.cpu_we;
                        bus.mem_read_en  = !bus.cpu_we;
                        if (!bus.cpu_we) begin
                            state_nxt     = RD_WAIT;
                            lat_ct_nxt    = LAT_INIT;
                            owner_dma_nxt = 1'b0;
                        end
                    end else if (dma_win) begin
                        bus.dma_gnt      = 1'b1;
                        bus.mem_addr     = bus.dma_addr;
                        bus.mem_wdata    = bus.dma_wdata;
                        bus.mem_write_en = bus.dma_we;
                        bus.mem_read_en  = !bus.dma_we;
                        if (!bus.dma_we) begin
                            state_nxt     = RD_WAIT;
                            lat_ct_nxt    = LAT_INIT;
                            owner_dma_nxt = 1'b1;
                        end
                    end
                    if (dma_win || !bus.dma_req) begin
                        burst_ct_nxt = 4'd0;
                    end else if (cpu_win && burst_ct != BURST_LIM) begin
                        burst_ct_nxt = burst_ct + 4'd1;
                    end
                end
                RD_WAIT: begin
                    lat_ct_nxt = lat_ct - 2'd1;
                    if (lat_ct == 2'd1) begin
                        state_nxt = IDLE;
                        if (owner_dma) begin
                            bus.dma_rvalid = 1'b1;
                            bus.dma_rdata  = bus.mem_rdata;
                        end else begin
                            bus.cpu_rvalid = 1'b1;
                            bus.cpu_rdata  = bus.mem_rdata;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            bus.cpu_stall = bus.cpu_req && !cpu_win;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cpu_grant_ct <= 16'd0;
            dma_grant_ct <= 16'd0;
            stall_ct     <= 16'd0;
        end else begin
            if (bus.cpu_gnt && cpu_grant_ct != 16'hFFFF) begin
                cpu_grant_ct <= cpu_grant_ct + 16'd1;
            end
            if (bus.dma_gnt && dma_grant_ct != 16'hFFFF) begin
                dma_grant_ct <= dma_grant_ct + 16'd1;
            end
            if (bus.cpu_stall && stall_ct != 16'hFFFF) begin
                stall_ct <= stall_ct + 16'd1;
            end
        end
    end
`endif

endmodule
